// File: rtl/data_mem_ctrl_pkg.sv
// rtl/data_mem_ctrl_pkg.sv - shared encodings and helpers for the tinyRISC data-memory controller
package data_mem_ctrl_pkg;

  typedef logic [1:0] mem_size_t;

  localparam mem_size_t SZ_BYTE = 2'b00;
  localparam mem_size_t SZ_HALF = 2'b01;
  localparam mem_size_t SZ_WORD = 2'b10;
  localparam mem_size_t SZ_RSVD = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Byte-enable mask for lane 0; the caller shifts it to the addressed lane.
  function automatic logic [3:0] be_base(input mem_size_t size);
    case (size)
      SZ_BYTE: be_base = 4'b0001;
      SZ_HALF: be_base = 4'b0011;
      SZ_WORD: be_base = 4'b1111;
      default: be_base = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/sp_ram_be.sv
// rtl/sp_ram_be.sv - synchronous single-port RAM with byte write enables and registered read
module sp_ram_be #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [DATA_W/8-1:0]      be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Read-during-write returns the old word; the controller never needs the new one here.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < NB; b++) begin
        if (we && be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - MEM-stage data-memory controller: handshake, wait states, sized access, error flag
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              cap_we;
  mem_size_t         cap_size;
  logic              cap_unsigned;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;

  logic              accept;
  logic              cur_we;
  mem_size_t         cur_size;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [1:0]        lane;
  logic              cur_err;
  logic              ram_en;
  logic [3:0]        ram_be;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] load_data;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;

  // With zero wait states the RAM is hit on the accept edge, so decode from the live request.
  assign cur_we    = (state == ST_IDLE) ? req_we    : cap_we;
  assign cur_size  = (state == ST_IDLE) ? req_size  : cap_size;
  assign cur_addr  = (state == ST_IDLE) ? req_addr  : cap_addr;
  assign cur_wdata = (state == ST_IDLE) ? req_wdata : cap_wdata;
  assign lane      = cur_addr[1:0];

  assign cur_err = ((cur_addr >> (IDX_W + 2)) != '0)
                || (cur_size == SZ_RSVD)
                || (cur_size == SZ_HALF && cur_addr[0])
                || (cur_size == SZ_WORD && cur_addr[1:0] != 2'b00);

  assign ram_en = (state == ST_WAIT && cnt == 4'd0) || (accept && WAIT_CYCLES == 0);
  assign ram_be = be_base(cur_size) << lane;

  always_comb begin
    ram_wdata = cur_wdata;
    case (cur_size)
      SZ_BYTE: ram_wdata = {4{cur_wdata[7:0]}};
      SZ_HALF: ram_wdata = {2{cur_wdata[15:0]}};
      default: ram_wdata = cur_wdata;
    endcase
  end

  sp_ram_be #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (cur_we && !cur_err),
    .be    (ram_be),
    .addr  (cur_addr[IDX_W+1:2]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign shifted = ram_rdata >> {cap_addr[1:0], 3'b000};

  always_comb begin
    load_data = ram_rdata;
    case (cap_size)
      SZ_BYTE: load_data = cap_unsigned ? {{(DATA_W-8){1'b0}}, shifted[7:0]}
                                        : {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = cap_unsigned ? {{(DATA_W-16){1'b0}}, shifted[15:0]}
                                        : {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      default: load_data = ram_rdata;
    endcase
  end

  assign rsp_valid = (state == ST_RESP);
  assign rsp_err   = rsp_valid && cur_err;
  assign rsp_rdata = (rsp_valid && !cap_we && !cur_err) ? load_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= 4'd0;
      cap_we       <= 1'b0;
      cap_size     <= SZ_BYTE;
      cap_unsigned <= 1'b0;
      cap_addr     <= '0;
      cap_wdata    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cap_we       <= req_we;
            cap_size     <= req_size;
            cap_unsigned <= req_unsigned;
            cap_addr     <= req_addr;
            cap_wdata    <= req_wdata;
            if (WAIT_CYCLES == 0) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) state <= ST_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - randomized byte-level reference checking for data_mem_ctrl at 0, 1 and 3 wait states
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid    [3];
  logic        req_ready    [3];
  logic        req_we       [3];
  logic [1:0]  req_size     [3];
  logic        req_unsigned [3];
  logic [31:0] req_addr     [3];
  logic [31:0] req_wdata    [3];
  logic        rsp_valid    [3];
  logic        rsp_ready    [3];
  logic [31:0] rsp_rdata    [3];
  logic        rsp_err      [3];

  logic [7:0]  mem_model [3][4096];
  int n_checks = 0;
  int n_pass   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  data_mem_ctrl #(.WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  data_mem_ctrl #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  data_mem_ctrl #(.WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_size(req_size[2]), .req_unsigned(req_unsigned[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]),
    .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

  function automatic int wait_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Little-endian byte memory; a load gathers 1/2/4 bytes and extends.
  task automatic model_access(input int i, input bit we, input logic [1:0] sz, input bit uns,
                              input logic [31:0] addr, input logic [31:0] wd,
                              output logic [31:0] d, output bit e);
    int nb;
    logic [31:0] v;
    logic [31:0] mask;
    e = (addr >= 32'h1000) || (sz == 2'd3) || (sz == 2'd1 && addr[0]) ||
        (sz == 2'd2 && addr[1:0] != 2'b00);
    d = 32'h0;
    if (!e) begin
      nb = 1 << sz;
      if (we) begin
        for (int b = 0; b < nb; b++) mem_model[i][addr[11:0] + b] = wd[8*b +: 8];
      end else begin
        v = 32'h0;
        for (int b = 0; b < nb; b++) v = v | (32'(mem_model[i][addr[11:0] + b]) << (8*b));
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
        if (!uns && nb < 4 && v[8*nb-1]) v = v | ~mask;
        d = v;
      end
    end
  endtask

  task automatic do_req(input int i, input bit we, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wd, input int hold);
    int lat;
    logic [31:0] exp_d;
    bit exp_e;
    logic [31:0] held;
    model_access(i, we, sz, uns, addr, wd, exp_d, exp_e);
    lat = 0;
    while (!req_ready[i] && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    check_eq("req_ready_idle", req_ready[i], 1);
    req_we[i] = we; req_size[i] = sz; req_unsigned[i] = uns;
    req_addr[i] = addr; req_wdata[i] = wd; req_valid[i] = 1'b1;
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    req_we[i] = 1'b1; req_addr[i] = $urandom; req_wdata[i] = $urandom; req_size[i] = 2'($urandom);
    lat = 1;
    while (!rsp_valid[i] && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    check_eq("rsp_valid", rsp_valid[i], 1);
    check_eq("latency", lat, wait_of(i) + 1);
    check_eq("rsp_err", rsp_err[i], exp_e);
    check_eq("rsp_rdata", rsp_rdata[i], exp_d);
    held = rsp_rdata[i];
    for (int k = 0; k < hold; k++) begin
      req_valid[i] = 1'b1;
      req_addr[i] = {24'h0, 8'($urandom)} & 32'hFC; req_size[i] = 2'd2;
      @(posedge clk); #1;
      req_valid[i] = 1'b0;
      check_eq("hold_ready_low", req_ready[i], 0);
      check_eq("hold_valid", rsp_valid[i], 1);
      check_eq("hold_rdata", rsp_rdata[i], held);
    end
    rsp_ready[i] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[i] = 1'b0;
    check_eq("rsp_released", rsp_valid[i], 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  s;
    int          inst;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 0; req_we[i] = 0; req_size[i] = 0; req_unsigned[i] = 0;
      req_addr[i] = 0; req_wdata[i] = 0; rsp_ready[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_req_ready", req_ready[0], 1);
    check_eq("reset_rsp_valid", rsp_valid[0], 0);
    check_eq("reset_rsp_rdata", rsp_rdata[0], 0);
    check_eq("reset_rsp_err", rsp_err[0], 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // RAM is not cleared by reset, so give every word the model uses a known value.
    for (int i = 0; i < 3; i++)
      for (int w = 0; w < 64; w++) do_req(i, 1, 2'd2, 0, 32'(w * 4), $urandom, 0);

    do_req(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0);
    do_req(0, 0, 2'd2, 0, 32'h10, 32'h0, 0);
    do_req(0, 1, 2'd0, 0, 32'h13, 32'h80, 0);
    do_req(0, 0, 2'd0, 0, 32'h13, 32'h0, 0);
    do_req(0, 0, 2'd0, 1, 32'h13, 32'h0, 0);
    do_req(0, 0, 2'd2, 0, 32'h10, 32'h0, 0);
    do_req(0, 1, 2'd1, 0, 32'h22, 32'h1234, 0);
    do_req(0, 0, 2'd1, 0, 32'h21, 32'h0, 0);
    do_req(0, 0, 2'd2, 0, 32'h20, 32'h0, 0);
    do_req(0, 1, 2'd2, 0, 32'h1000, 32'hCAFEF00D, 0);
    do_req(0, 0, 2'd2, 0, 32'h0, 32'h0, 0);
    do_req(0, 0, 2'd2, 0, 32'h10, 32'h0, 5);

    // Reset while the store is still waiting: it must never reach the RAM.
    req_we[0] = 1; req_size[0] = 2'd2; req_unsigned[0] = 0;
    req_addr[0] = 32'h40; req_wdata[0] = 32'hA5A5A5A5; req_valid[0] = 1;
    @(posedge clk); #1;
    req_valid[0] = 0;
    check_eq("mid_wait_state", rsp_valid[0], 0);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_req_ready", req_ready[0], 1);
    check_eq("midrst_rsp_valid", rsp_valid[0], 0);
    check_eq("midrst_rsp_rdata", rsp_rdata[0], 0);
    check_eq("midrst_rsp_err", rsp_err[0], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(0, 0, 2'd2, 0, 32'h40, 32'h0, 0);

    for (int n = 0; n < 300; n++) begin
      inst = $urandom_range(0, 2);
      s = 2'($urandom);
      a = $urandom_range(0, 255);
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << s) - 32'd1);
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 255)) << 12);
      if (s == 2'd3 && $urandom_range(0, 1) == 0) s = 2'd2;
      do_req(inst, 1'($urandom), s, 1'($urandom), a, $urandom,
             ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
